// File: rtl/fmul_pkg.sv
// fmul_pkg: shared double-precision format constants and operand class encoding
package fmul_pkg;
    localparam int DATA_WIDTH = 64;
    localparam int EXP = 11;
    localparam int MANT = 52;
    localparam int BIAS = 1023;
    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_SUB  = 3'd1,
        CLS_NORM = 3'd2,
        CLS_INF  = 3'd3,
        CLS_QNAN = 3'd4,
        CLS_SNAN = 3'd5
    } cls_e;
    localparam logic [DATA_WIDTH-1:0] CANON_NAN = 64'h7FF8_0000_0000_0000;
    function automatic logic is_nan(input cls_e c);
        return (c == CLS_QNAN) || (c == CLS_SNAN);
    endfunction
    // Subnormals are flushed, so they act as zero when selecting results
    function automatic logic is_zero(input cls_e c);
        return (c == CLS_ZERO) || (c == CLS_SUB);
    endfunction
endpackage

// File: rtl/fmul_operand_stage_if.sv
// fmul_operand_stage_if: operand handshake in, staged operands and flags out
interface fmul_operand_stage_if #(parameter int DATA_WIDTH = 64);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] a_i;
    logic [DATA_WIDTH-1:0] b_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] a_o;
    logic [DATA_WIDTH-1:0] b_o;
    logic [2:0]            cls_a_o;
    logic [2:0]            cls_b_o;
    logic                  special_o;
    logic [DATA_WIDTH-1:0] special_res_o;
    logic                  invalid_o;
    modport master (
        output in_valid_i, a_i, b_i, out_ready_i,
        input  in_ready_o, out_valid_o, a_o, b_o, cls_a_o, cls_b_o,
               special_o, special_res_o, invalid_o
    );
    modport slave (
        input  in_valid_i, a_i, b_i, out_ready_i,
        output in_ready_o, out_valid_o, a_o, b_o, cls_a_o, cls_b_o,
               special_o, special_res_o, invalid_o
    );
endinterface

// File: rtl/fp_classify.sv
// fp_classify: combinational IEEE-754 operand classifier
module fp_classify
    import fmul_pkg::*;
#(
    parameter int EXP  = fmul_pkg::EXP,
    parameter int MANT = fmul_pkg::MANT
) (
    input  logic [EXP+MANT:0] x,
    output cls_e              cls
);
    logic [EXP-1:0]  exp_f;
    logic [MANT-1:0] mant_f;
    assign exp_f  = x[EXP+MANT-1:MANT];
    assign mant_f = x[MANT-1:0];
    always_comb begin
        cls = (exp_f == '0) ? ((mant_f == '0) ? CLS_ZERO : CLS_SUB) :
              (&exp_f)      ? ((mant_f == '0) ? CLS_INF :
                               mant_f[MANT-1] ? CLS_QNAN : CLS_SNAN) :
                              CLS_NORM;
    end
endmodule

// File: rtl/fmul_operand_stage.sv
// fmul_operand_stage: classifies operand pairs, precomputes special results, skid-buffered
module fmul_operand_stage
    import fmul_pkg::*;
#(
    parameter int DATA_WIDTH = fmul_pkg::DATA_WIDTH,
    parameter int EXP        = fmul_pkg::EXP,
    parameter int MANT       = fmul_pkg::MANT
) (
    input logic                 clk_i,
    input logic                 rst_i,
    fmul_operand_stage_if.slave bus
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [DATA_WIDTH-1:0] res;
        cls_e                  cls_a;
        cls_e                  cls_b;
        logic                  special;
        logic                  invalid;
    } stage_t;
    cls_e   cls_a, cls_b;
    logic   sgn, any_nan, any_inf, any_zero, any_snan;
    stage_t in_d, main_q, main_d, skid_q, skid_d;
    logic   main_v, main_vd, skid_v, skid_vd, ready_q, accept;
    fp_classify #(.EXP(EXP), .MANT(MANT)) u_cls_a (.x(bus.a_i), .cls(cls_a));
    fp_classify #(.EXP(EXP), .MANT(MANT)) u_cls_b (.x(bus.b_i), .cls(cls_b));
    assign sgn      = bus.a_i[DATA_WIDTH-1] ^ bus.b_i[DATA_WIDTH-1];
    assign any_nan  = is_nan(cls_a) || is_nan(cls_b);
    assign any_inf  = (cls_a == CLS_INF) || (cls_b == CLS_INF);
    assign any_zero = is_zero(cls_a) || is_zero(cls_b);
    assign any_snan = (cls_a == CLS_SNAN) || (cls_b == CLS_SNAN);
    always_comb begin
        in_d.a       = bus.a_i;
        in_d.b       = bus.b_i;
        in_d.cls_a   = cls_a;
        in_d.cls_b   = cls_b;
        in_d.special = (cls_a != CLS_NORM) || (cls_b != CLS_NORM);
        in_d.invalid = any_snan || (any_inf && any_zero);
        in_d.res     = (any_nan || (any_inf && any_zero)) ? CANON_NAN :
                       any_inf  ? {sgn, {EXP{1'b1}}, {MANT{1'b0}}} :
                       any_zero ? {sgn, {(DATA_WIDTH-1){1'b0}}} :
                                  '0;
    end
    // in_ready is !skid_v registered, so an accept never coincides with a full skid
    assign accept = bus.in_valid_i && ready_q;
    always_comb begin
        main_d  = main_q;
        main_vd = main_v;
        skid_d  = skid_q;
        skid_vd = skid_v;
        if (!main_v || bus.out_ready_i) begin
            if (skid_v) begin
                main_d  = skid_q;
                main_vd = 1'b1;
                skid_vd = 1'b0;
            end else if (accept) begin
                main_d  = in_d;
                main_vd = 1'b1;
            end else begin
                main_vd = 1'b0;
            end
        end else if (accept) begin
            skid_d  = in_d;
            skid_vd = 1'b1;
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_q  <= '0;
            skid_q  <= '0;
            main_v  <= 1'b0;
            skid_v  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            main_q  <= main_d;
            skid_q  <= skid_d;
            main_v  <= main_vd;
            skid_v  <= skid_vd;
            ready_q <= !skid_vd;
        end
    end
    assign bus.in_ready_o    = ready_q;
    assign bus.out_valid_o   = main_v;
    assign bus.a_o           = main_q.a;
    assign bus.b_o           = main_q.b;
    assign bus.cls_a_o       = main_q.cls_a;
    assign bus.cls_b_o       = main_q.cls_b;
    assign bus.special_o     = main_q.special;
    assign bus.special_res_o = main_q.res;
    assign bus.invalid_o     = main_q.invalid;
endmodule

// File: tb/tb_fmul_operand_stage.sv
// tb_fmul_operand_stage: directed vector table plus skid and reset sequences
module tb_fmul_operand_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    fmul_operand_stage_if #(.DATA_WIDTH(64)) bus ();
    fmul_operand_stage dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  cls_a;
        logic [2:0]  cls_b;
        logic        special;
        logic [63:0] res;
        logic        invalid;
    } vec_t;
    vec_t vecs[12];
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b);
        bus.in_valid_i = v;
        bus.a_i = a;
        bus.b_i = b;
    endtask
    initial begin
        vecs[0]  = '{64'h4008_0000_0000_0000, 64'h4000_0000_0000_0000, 3'd2, 3'd2, 1'b0, 64'h0, 1'b0};
        vecs[1]  = '{64'h7FF0_0000_0000_0000, 64'h0, 3'd3, 3'd0, 1'b1, 64'h7FF8_0000_0000_0000, 1'b1};
        vecs[2]  = '{64'h0000_0000_0000_0001, 64'hC000_0000_0000_0000, 3'd1, 3'd2, 1'b1, 64'h8000_0000_0000_0000, 1'b0};
        vecs[3]  = '{64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000, 3'd5, 3'd2, 1'b1, 64'h7FF8_0000_0000_0000, 1'b1};
        vecs[4]  = '{64'h7FF8_0000_0000_0000, 64'h0, 3'd4, 3'd0, 1'b1, 64'h7FF8_0000_0000_0000, 1'b0};
        vecs[5]  = '{64'hFFF0_0000_0000_0000, 64'h4000_0000_0000_0000, 3'd3, 3'd2, 1'b1, 64'hFFF0_0000_0000_0000, 1'b0};
        vecs[6]  = '{64'h8000_0000_0000_0000, 64'hC008_0000_0000_0000, 3'd0, 3'd2, 1'b1, 64'h0, 1'b0};
        vecs[7]  = '{64'h7FF0_0000_0000_0000, 64'h000F_FFFF_FFFF_FFFF, 3'd3, 3'd1, 1'b1, 64'h7FF8_0000_0000_0000, 1'b1};
        vecs[8]  = '{64'h7FF8_0000_0000_0000, 64'hFFF0_0000_0000_0001, 3'd4, 3'd5, 1'b1, 64'h7FF8_0000_0000_0000, 1'b1};
        vecs[9]  = '{64'hFFF0_0000_0000_0000, 64'hFFF0_0000_0000_0000, 3'd3, 3'd3, 1'b1, 64'h7FF0_0000_0000_0000, 1'b0};
        vecs[10] = '{64'hBFF0_0000_0000_0000, 64'h4000_0000_0000_0000, 3'd2, 3'd2, 1'b0, 64'h0, 1'b0};
        vecs[11] = '{64'h7FEF_FFFF_FFFF_FFFF, 64'h0010_0000_0000_0000, 3'd2, 3'd2, 1'b0, 64'h0, 1'b0};
        drive(1'b0, 64'h0, 64'h0);
        bus.out_ready_i = 1'b1;
        step();
        step();
        check("rst out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst in_ready", 64'(bus.in_ready_o), 64'd1);
        check("rst a_o", bus.a_o, 64'h0);
        check("rst res", bus.special_res_o, 64'h0);
        check("rst flags", {59'd0, bus.cls_a_o, bus.special_o, bus.invalid_o}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        // Back-to-back streaming of the whole table at full throughput
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].a, vecs[i].b);
            step();
            check($sformatf("v%0d valid", i), 64'(bus.out_valid_o), 64'd1);
            check($sformatf("v%0d ready", i), 64'(bus.in_ready_o), 64'd1);
            check($sformatf("v%0d a_o", i), bus.a_o, vecs[i].a);
            check($sformatf("v%0d b_o", i), bus.b_o, vecs[i].b);
            check($sformatf("v%0d cls", i), {58'd0, bus.cls_a_o, bus.cls_b_o}, {58'd0, vecs[i].cls_a, vecs[i].cls_b});
            check($sformatf("v%0d special", i), 64'(bus.special_o), 64'(vecs[i].special));
            check($sformatf("v%0d res", i), bus.special_res_o, vecs[i].res);
            check($sformatf("v%0d invalid", i), 64'(bus.invalid_o), 64'(vecs[i].invalid));
        end
        @(negedge clk);
        drive(1'b0, 64'h0, 64'h0);
        step();
        check("drain out_valid", 64'(bus.out_valid_o), 64'd0);
        // Back-pressure: three beats with the consumer stalled
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        drive(1'b1, 64'h1111, 64'h4000_0000_0000_0000);
        step();
        check("bp1 a_o", bus.a_o, 64'h1111);
        check("bp1 ready", 64'(bus.in_ready_o), 64'd1);
        @(negedge clk);
        drive(1'b1, 64'h2222, 64'h4000_0000_0000_0000);
        step();
        check("bp2 a_o held", bus.a_o, 64'h1111);
        check("bp2 ready", 64'(bus.in_ready_o), 64'd0);
        @(negedge clk);
        drive(1'b1, 64'h3333, 64'h4000_0000_0000_0000);
        step();
        check("bp3 a_o held", bus.a_o, 64'h1111);
        check("bp3 ready", 64'(bus.in_ready_o), 64'd0);
        check("bp3 cls_a held", 64'(bus.cls_a_o), 64'd1);
        @(negedge clk);
        bus.out_ready_i = 1'b1;
        step();
        check("rel beat2", bus.a_o, 64'h2222);
        check("rel ready", 64'(bus.in_ready_o), 64'd1);
        step();
        check("rel beat3", bus.a_o, 64'h3333);
        check("rel beat3 valid", 64'(bus.out_valid_o), 64'd1);
        @(negedge clk);
        drive(1'b0, 64'h0, 64'h0);
        step();
        check("rel empty", 64'(bus.out_valid_o), 64'd0);
        // Reset with both registers occupied
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        drive(1'b1, 64'h4444, 64'h4000_0000_0000_0000);
        @(negedge clk);
        drive(1'b1, 64'h5555, 64'h4000_0000_0000_0000);
        @(negedge clk);
        drive(1'b0, 64'h0, 64'h0);
        check("pre-rst full", {62'd0, bus.out_valid_o, bus.in_ready_o}, 64'b10);
        rst = 1'b1;
        #1;
        check("rst async valid", 64'(bus.out_valid_o), 64'd0);
        check("rst async ready", 64'(bus.in_ready_o), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("post-rst stale %0d", i), {63'd0, bus.out_valid_o}, 64'd0);
        end
        check("post-rst a_o", bus.a_o, 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fmul_operand_stage.md
# fmul_operand_stage

Registered operand-staging stage directly upstream of the combinational double-precision multiplier. Accepts operand pairs over a valid/ready handshake, classifies each operand (zero, subnormal, normal, infinity, quiet/signalling NaN), precomputes the IEEE-754 special-case result, and presents registered operands plus flags to the multiplier. A two-entry skid buffer gives full throughput with a registered `in_ready_o`. The downstream mux selects `special_res_o` over the multiplier output when `special_o` is set.

## Interface
- `DATA_WIDTH`, 64: operand width.
- `EXP`, 11: exponent field width.
- `MANT`, 52: stored mantissa width.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `in_valid_i` in 1: operand pair valid.
- `in_ready_o` out 1: stage can accept; registered.
- `a_i`, `b_i` in DATA_WIDTH: operands.
- `out_valid_o` out 1: staged pair valid.
- `out_ready_i` in 1: multiplier side accepts.
- `a_o`, `b_o` out DATA_WIDTH: staged operands, unmodified bits.
- `cls_a_o`, `cls_b_o` out 3: class: 0 ZERO, 1 SUB, 2 NORM, 3 INF, 4 QNAN, 5 SNAN.
- `special_o` out 1: either class is not NORM; multiplier result must be replaced.
- `special_res_o` out DATA_WIDTH: replacement result, valid when `special_o`=1.
- `invalid_o` out 1: IEEE invalid-operation (any SNAN input, or INF × ZERO/SUB).

## Operation
- Classification (combinational on `a_i`/`b_i`, captured with data): exp=0 & mant=0 → ZERO; exp=0 & mant≠0 → SUB; exp all-ones & mant=0 → INF; exp all-ones & mant MSB=1 → QNAN; exp all-ones & mant MSB=0 & mant≠0 → SNAN; else NORM.
- Subnormals are flushed to zero (FTZ): SUB treated as ZERO for result selection.
- Result sign s = sign(a) ^ sign(b). Priority of `special_res_o`:
  1. any QNAN/SNAN → canonical NaN 0x7FF8_0000_0000_0000;
  2. INF with ZERO/SUB → canonical NaN, `invalid_o`=1;
  3. any INF → {s, all-ones exp, 0 mant};
  4. any ZERO/SUB → {s, 0, 0} (signed zero);
  5. both NORM → `special_o`=0, `special_res_o`=0.
- `invalid_o` also 1 whenever either class is SNAN.
- Skid buffer: main register (drives outputs) plus one skid register, each holding data, classes and flags.
  - Accept = `in_valid_i` & `in_ready_o`.
  - Accept with main empty or `out_ready_i`=1 → load main from input.
  - Accept with main full and `out_ready_i`=0 → load skid; skid becomes full.
  - Skid full and `out_ready_i`=1 → main ← skid, skid empties.
  - `in_ready_o` next = !skid_full next.
  - Main empties when `out_ready_i`=1 and no new load.
- Strict FIFO ordering; no beat dropped or duplicated.

## Timing
- Reset (async assert, sync release): `out_valid_o`=0, `in_ready_o`=1, skid empty, all data/class/flag outputs 0.
- Latency: accepted beat appears on outputs the next cycle.
- Throughput: one pair per cycle while `out_ready_i`=1.
- Output stable while `out_valid_o`=1 & `out_ready_i`=0.
- `in_ready_o` falls the cycle after the skid fills and rises the cycle after it drains.
- Reset mid-transfer: all in-flight beats discarded; `out_valid_o` low immediately on assertion.
- No combinational path from `out_ready_i` to `in_ready_o`.

## Structure
- Shared package `fmul_pkg`: class encoding constants, canonical NaN constant, format parameters (EXP, MANT, BIAS).
- One sub-module: `fp_classify` (combinational, one operand → 3-bit class); instantiated twice at the input.
- Special-result logic and skid buffer stay in the top module.

## Test plan
- 3.0 × 2.0 (a=0x4008_0000_0000_0000, b=0x4000_0000_0000_0000), `out_ready_i`=1 → next cycle `out_valid_o`=1, classes 2/2, `special_o`=0, `invalid_o`=0.
- +Inf × +0 (0x7FF0_0000_0000_0000, 0) → `special_o`=1, `special_res_o`=0x7FF8_0000_0000_0000, `invalid_o`=1.
- Subnormal 0x0000_0000_0000_0001 × −2.0 (0xC000_0000_0000_0000) → cls_a=1, `special_res_o`=0x8000_0000_0000_0000, `invalid_o`=0.
- sNaN 0x7FF0_0000_0000_0001 × 1.0 → cls_a=5, canonical NaN, `invalid_o`=1.
- `out_ready_i`=0, three back-to-back beats → beat 1 in main, beat 2 in skid, `in_ready_o`=0, beat 3 held off; release → beats emerge 1,2,3 on consecutive cycles.
- Assert `rst_i` with main and skid full → `out_valid_o`=0 same cycle; after release `in_ready_o`=1, no stale beat emitted.
